// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin share of the HD44780 8-bit write bus between two requesters,
// with setup / enable / hold / execution-wait timing on every transfer.
module lcd_bus_arbiter #(
  parameter int T_SETUP     = 3,
  parameter int T_EN        = 13,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_init_done,
  input  logic       i_req0_valid,
  input  logic       i_req0_rs,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ack,
  input  logic       i_req1_valid,
  input  logic       i_req1_rs,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ack,
  output logic       o_busy,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_dados
);
  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, EXEC} state_t;
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(T_EXEC_LONG - 1);
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_lim;
  logic             r_last_grant, r_long;
  logic             w_last, w_accept, w_pick1, w_rs, w_long;
  logic [7:0]       w_data;
  assign o_lcd_rw = 1'b0;
  always_comb begin
    w_lim = r_state == SETUP ? L_SETUP : r_state == ENABLE ? L_EN :
            r_state == HOLD ? L_HOLD : r_long ? L_LONG : L_EXEC;
    w_last = r_cnt == w_lim;
    w_accept = r_state == IDLE && i_init_done && (i_req0_valid || i_req1_valid);
    // a tie goes to whoever was not granted last
    w_pick1 = i_req1_valid && (!i_req0_valid || !r_last_grant);
    w_rs = w_pick1 ? i_req1_rs : i_req0_rs;
    w_data = w_pick1 ? i_req1_data : i_req0_data;
    // Clear Display / Return Home need the long execution wait
    w_long = !w_rs && w_data[7:2] == 6'd0 && w_data[1:0] != 2'd0;
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = w_accept ? SETUP : IDLE;
      SETUP:   w_state_nx = w_last ? ENABLE : SETUP;
      ENABLE:  w_state_nx = w_last ? HOLD : ENABLE;
      HOLD:    w_state_nx = w_last ? EXEC : HOLD;
      EXEC:    w_state_nx = w_last ? IDLE : EXEC;
      default: w_state_nx = IDLE;
    endcase
    w_cnt_nx = (r_state == IDLE || w_last) ? '0 : r_cnt + CNT_W'(1);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_long       <= 1'b0;
      o_lcd_en     <= 1'b0;
      o_lcd_rs     <= 1'b0;
      o_lcd_dados  <= 8'h00;
      o_req0_ack   <= 1'b0;
      o_req1_ack   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      o_lcd_en   <= w_state_nx == ENABLE;
      o_busy     <= w_state_nx != IDLE;
      o_req0_ack <= w_accept && !w_pick1;
      o_req1_ack <= w_accept && w_pick1;
      if (w_accept) begin
        o_lcd_rs     <= w_rs;
        o_lcd_dados  <= w_data;
        r_last_grant <= w_pick1;
        r_long       <= w_long;
      end
    end
  end
endmodule
